register_access_sequencer: RTL and testbench
============================================

# register_access_sequencer

Upstream controller for the register address pointer in the PWM IO expander. It turns decoded I2C slave events into the pointer's next-address value. The first written byte of a transaction is loaded as the pointer, and the pointer auto-increments after every written or read data byte. It also issues the register-file write strobe. `NewAddress` drives the pointer's next-address input, and the pointer's `AddressBus` output is fed back here.

## Interface
- `AddressWidth`, 8, width of register address
- `MaxAddress`, 8'h1F, highest valid register index; increment wraps to 0 after it

- `CLK`  in  1  system clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `StartCond`  in  1  one-cycle pulse; START or repeated START detected
- `StopCond`  in  1  one-cycle pulse; STOP detected
- `AddrMatch`  in  1  one-cycle pulse; slave address matched and ACKed
- `RwBit`  in  1  R/W bit of matched address; valid with `AddrMatch` (1 = read)
- `RxValid`  in  1  one-cycle pulse; data byte received and ACKed
- `RxData`  in  8  received byte; valid with `RxValid`
- `TxDone`  in  1  one-cycle pulse; read byte sent and ACKed by master
- `AddressBus`  in  AddressWidth  current pointer value (feedback)
- `NewAddress`  out  AddressWidth  next pointer value
- `RegWrite`  out  1  one-cycle write strobe to register file at `AddressBus`
- `RegWriteData`  out  8  write data; valid with `RegWrite`
- `AddrError`  out  1  one-cycle pulse; pointer byte exceeded `MaxAddress`
- `Busy`  out  1  high when state ≠ IDLE

## Operation
- Four states: IDLE, PTR, WRITE, READ.
- Event priority:
  - `StartCond` or `StopCond` forces IDLE and drops any same-cycle `AddrMatch`, `RxValid` or `TxDone`.
  - The pointer value is kept, so a write-pointer then repeated-START read works.
- Transitions:
  - IDLE: `AddrMatch` & !`RwBit` → PTR; `AddrMatch` & `RwBit` → READ; other events are ignored.
  - PTR: `RxValid` → load pointer, then WRITE.
  - WRITE: each `RxValid` → register write, then increment.
  - READ: each `TxDone` → increment.
  - `TxDone` in WRITE/PTR and `RxValid` in READ are ignored.
- Pointer load:
  - `RxData[AddressWidth-1:0]` is loaded if ≤ `MaxAddress`.
  - Otherwise 0 is loaded, `AddrError` pulses, and the block still enters WRITE.
- Increment: `AddressBus == MaxAddress` → 0, else `AddressBus + 1`, modulo 2^AddressWidth.
- `NewAddress` is combinational from registered flags:
  - load flag → load value
  - else increment flag → wrapped increment
  - else `AddressBus` (hold)
  - Load and increment flags are never set together.

## Timing
- Reset values: state IDLE, all flags 0, `RegWrite` = 0, `RegWriteData` = 0, `AddrError` = 0, `Busy` = 0, `NewAddress` = `AddressBus`.
- Reset mid-transaction aborts immediately; any pending strobe or increment is discarded.
- Pointer byte:
  - `RxValid` in PTR at cycle N → load flag high at N+1.
  - `AddressBus` shows the new pointer at N+2.
  - `AddrError` is high at N+1 on clamp.
- Write byte:
  - `RxValid` in WRITE at cycle N → `RegWrite` and `RegWriteData` at N+1, addressing the old `AddressBus`.
  - The increment flag is also high at N+1, and `AddressBus` advances at N+2.
- Read byte: `TxDone` at N → increment flag at N+1 → `AddressBus` advances at N+2.
- Back-to-back `RxValid`/`TxDone` pulses at minimum spacing of 2 cycles must be handled; the I2C layer guarantees at least 8 cycles.
- A STOP/START arriving while a flag is set does not cancel it; the flag was registered from an earlier byte and completes.
- `Busy` drops the cycle after `StopCond`.

## Structure
- A shared package holds:
  - state encoding localparams: IDLE = 2'b00, PTR = 2'b01, WRITE = 2'b10, READ = 2'b11
  - default `MaxAddress`
  - a wrap-increment function
- Single module, single FSM; no sub-module needed.
- The pointer register stays in the existing pointer block; this block holds no copy of the address.

## Test plan
- Write 8'h05 then 8'hAA, 8'h55 → `RegWrite` at 5 with 8'hAA, at 6 with 8'h55; `AddressBus` ends at 7.
- Write pointer 8'h1E, then 3 bytes → writes at 1E, 1F, 00; `AddressBus` = 01.
- Pointer 8'h40 → `AddrError` pulse; `AddressBus` = 0; next byte writes at 0.
- Write pointer 8'h10, repeated START, read match, 3× `TxDone` → no `RegWrite`; `AddressBus` = 8'h13.
- `StopCond` coincident with `RxValid` in WRITE → no `RegWrite`; IDLE; pointer unchanged.
- `RST` pulse one cycle after `RxValid` in WRITE → no `RegWrite`; all outputs at reset values; `Busy` = 0.

Source files
------------

// File: rtl/register_access_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// register_access_sequencer_pkg
//
// Shared definitions for the register access sequencer:
//   - state encoding of the sequencer FSM
//   - default address width and highest valid register index
//   - wrap-around pointer increment helper
// ---------------------------------------------------------------------------
package register_access_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'b00;
    localparam state_t PTR   = 2'b01;
    localparam state_t WRITE = 2'b10;
    localparam state_t READ  = 2'b11;

    localparam int         ADDRESS_WIDTH_DEFAULT = 8;
    localparam logic [7:0] MAX_ADDRESS_DEFAULT   = 8'h1F;

    // Next pointer value: wraps to 0 after max_addr. Callers truncate the
    // result to their address width, which gives the modulo-2^width
    // behaviour when the pointer sits at the all-ones value.
    function automatic logic [31:0] wrap_increment(input logic [31:0] addr,
                                                   input logic [31:0] max_addr);
        return (addr == max_addr) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/register_access_sequencer.sv
// ---------------------------------------------------------------------------
// register_access_sequencer
//
// Turns decoded I2C slave events into the next-address value of the external
// register address pointer and issues the register-file write strobe. The
// first written byte of a transaction loads the pointer; every further
// written byte, and every read byte acknowledged by the master, advances it.
// This block keeps no copy of the address: the pointer's AddressBus output is
// fed back and NewAddress drives the pointer's next-address input.
//
// Ports:
//   CLK, RST      clock (rising edge), asynchronous active-high reset
//   StartCond     START / repeated START pulse
//   StopCond      STOP pulse
//   AddrMatch     slave address matched pulse, RwBit valid with it (1 = read)
//   RxValid       data byte received pulse, RxData valid with it
//   TxDone        read byte sent and ACKed pulse
//   AddressBus    current pointer value (feedback)
//   NewAddress    next pointer value
//   RegWrite      one-cycle write strobe, addresses AddressBus
//   RegWriteData  write data, valid with RegWrite
//   AddrError     pointer byte exceeded MaxAddress (pointer forced to 0)
//   Busy          sequencer is inside a transaction
// ---------------------------------------------------------------------------
module register_access_sequencer
    import register_access_sequencer_pkg::*;
#(
    parameter int                      AddressWidth = ADDRESS_WIDTH_DEFAULT,
    parameter logic [AddressWidth-1:0] MaxAddress   = AddressWidth'(MAX_ADDRESS_DEFAULT)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    StartCond,
    input  logic                    StopCond,
    input  logic                    AddrMatch,
    input  logic                    RwBit,
    input  logic                    RxValid,
    input  logic [7:0]              RxData,
    input  logic                    TxDone,
    input  logic [AddressWidth-1:0] AddressBus,
    output logic [AddressWidth-1:0] NewAddress,
    output logic                    RegWrite,
    output logic [7:0]              RegWriteData,
    output logic                    AddrError,
    output logic                    Busy
);

    state_t state;
    state_t state_next;

    // Registered action flags; NewAddress is derived from these one cycle
    // after the triggering byte event.
    logic                    load_flag;
    logic                    inc_flag;
    logic [AddressWidth-1:0] load_value;

    logic                    load_next;
    logic                    inc_next;
    logic [AddressWidth-1:0] load_value_next;
    logic                    write_next;
    logic [7:0]              write_data_next;
    logic                    error_next;

    // A bus condition aborts the transaction and swallows any same-cycle
    // byte or match event.
    logic                    bus_cond;
    logic [AddressWidth-1:0] ptr_byte;

    assign bus_cond = StartCond | StopCond;
    assign ptr_byte = AddressWidth'(RxData);

    // -----------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (bus_cond) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (AddrMatch) state_next = RwBit ? READ : PTR;
                PTR:     if (RxValid)   state_next = WRITE;
                default: state_next = state;
            endcase
        end
    end

    // -----------------------------------------------------------------
    // Output logic: next values of the registered flags and strobes
    // -----------------------------------------------------------------
    always_comb begin
        load_next       = 1'b0;
        inc_next        = 1'b0;
        load_value_next = load_value;
        write_next      = 1'b0;
        write_data_next = RegWriteData;
        error_next      = 1'b0;
        if (!bus_cond) begin
            case (state)
                PTR: begin
                    if (RxValid) begin
                        load_next = 1'b1;
                        if (ptr_byte <= MaxAddress) begin
                            load_value_next = ptr_byte;
                        end else begin
                            load_value_next = '0;
                            error_next      = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (RxValid) begin
                        write_next      = 1'b1;
                        write_data_next = RxData;
                        inc_next        = 1'b1;
                    end
                end
                READ: begin
                    if (TxDone) inc_next = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Flags are registered independently of the state so a START/STOP on
    // the following cycle cannot cancel work already committed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            load_flag    <= 1'b0;
            inc_flag     <= 1'b0;
            load_value   <= '0;
            RegWrite     <= 1'b0;
            RegWriteData <= '0;
            AddrError    <= 1'b0;
        end else begin
            load_flag    <= load_next;
            inc_flag     <= inc_next;
            load_value   <= load_value_next;
            RegWrite     <= write_next;
            RegWriteData <= write_data_next;
            AddrError    <= error_next;
        end
    end

    always_comb begin
        NewAddress = AddressBus;
        if (load_flag) begin
            NewAddress = load_value;
        end else if (inc_flag) begin
            NewAddress = AddressWidth'(wrap_increment(32'(AddressBus), 32'(MaxAddress)));
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_register_access_sequencer.sv
// ---------------------------------------------------------------------------
// tb_register_access_sequencer
//
// Directed bench for register_access_sequencer. The external pointer register
// is modelled here (it follows NewAddress every cycle and is not reset by
// RST). Expected register writes and address errors are queued when the
// stimulus is issued; a monitor on the falling edge pops and compares them
// whenever RegWrite or AddrError is seen.
// ---------------------------------------------------------------------------
module tb_register_access_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_cond, stop_cond, addr_match, rw_bit, rx_valid, tx_done;
    logic [7:0] rx_data;
    logic [7:0] address_bus;
    logic [7:0] new_address;
    logic       reg_write;
    logic [7:0] reg_write_data;
    logic       addr_error;
    logic       busy;
    logic       ptr_preset;

    int compared   = 0;
    int mismatched = 0;

    typedef enum logic {EV_WRITE, EV_ERROR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    register_access_sequencer dut (
        .CLK          (clk),
        .RST          (rst),
        .StartCond    (start_cond),
        .StopCond     (stop_cond),
        .AddrMatch    (addr_match),
        .RwBit        (rw_bit),
        .RxValid      (rx_valid),
        .RxData       (rx_data),
        .TxDone       (tx_done),
        .AddressBus   (address_bus),
        .NewAddress   (new_address),
        .RegWrite     (reg_write),
        .RegWriteData (reg_write_data),
        .AddrError    (addr_error),
        .Busy         (busy)
    );

    // External pointer block model.
    always_ff @(posedge clk) begin
        if (ptr_preset) address_bus <= 8'h00;
        else            address_bus <= new_address;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reg_write) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_reg_write", 32'(address_bus), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write_kind", 32'(EV_WRITE), 32'(e.kind));
                    check("write_addr", 32'(address_bus), 32'(e.addr));
                    check("write_data", 32'(reg_write_data), 32'(e.data));
                end
            end
            if (addr_error) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_addr_error", 32'(address_bus), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("error_kind", 32'(EV_ERROR), 32'(e.kind));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Drive one cycle of events, then release them. Returns one cycle after
    // the sampling edge, i.e. in the cycle where registered flags are high.
    task automatic pulse(input logic s, input logic p, input logic m, input logic rw,
                         input logic rv, input logic [7:0] d, input logic td);
        start_cond = s; stop_cond = p; addr_match = m; rw_bit = rw;
        rx_valid = rv; rx_data = d; tx_done = td;
        step();
        start_cond = 1'b0; stop_cond = 1'b0; addr_match = 1'b0; rw_bit = 1'b0;
        rx_valid = 1'b0; tx_done = 1'b0;
    endtask

    task automatic begin_txn(input logic rw);
        pulse(1, 0, 0, 0, 0, 8'h00, 0);
        idle(2);
        pulse(0, 0, 1, rw, 0, 8'h00, 0);
        idle(2);
        check("busy_in_txn", 32'(busy), 32'd1);
    endtask

    task automatic end_txn(input logic [7:0] exp_ptr);
        pulse(0, 1, 0, 0, 0, 8'h00, 0);
        check("busy_after_stop", 32'(busy), 32'd0);
        idle(2);
        check("ptr_after_stop", 32'(address_bus), 32'(exp_ptr));
    endtask

    task automatic ptr_byte(input logic [7:0] d, input logic [7:0] exp_ptr, input logic exp_err);
        exp_t e;
        if (exp_err) begin
            e.kind = EV_ERROR; e.addr = 8'h00; e.data = 8'h00;
            exp_q.push_back(e);
        end
        pulse(0, 0, 0, 0, 1, d, 0);
        check("ptr_new_address", 32'(new_address), 32'(exp_ptr));
        step();
        check("ptr_address_bus", 32'(address_bus), 32'(exp_ptr));
        idle(2);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic [7:0] exp_addr, input logic [7:0] exp_next);
        exp_t e;
        e.kind = EV_WRITE; e.addr = exp_addr; e.data = d;
        exp_q.push_back(e);
        pulse(0, 0, 0, 0, 1, d, 0);
        check("wr_new_address", 32'(new_address), 32'(exp_next));
        step();
        check("wr_address_bus", 32'(address_bus), 32'(exp_next));
        idle(2);
    endtask

    task automatic read_byte(input logic [7:0] exp_next);
        pulse(0, 0, 0, 0, 0, 8'h00, 1);
        check("rd_new_address", 32'(new_address), 32'(exp_next));
        step();
        check("rd_address_bus", 32'(address_bus), 32'(exp_next));
        idle(2);
    endtask

    initial begin
        start_cond = 0; stop_cond = 0; addr_match = 0; rw_bit = 0;
        rx_valid = 0; rx_data = 8'h00; tx_done = 0;
        rst = 1'b1; ptr_preset = 1'b1;
        idle(3);

        // Reset state
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_reg_write_data", 32'(reg_write_data), 32'd0);
        check("rst_addr_error", 32'(addr_error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_new_address", 32'(new_address), 32'h00);
        rst = 1'b0; ptr_preset = 1'b0;
        idle(2);

        // Events in IDLE are ignored; START with same-cycle match is dropped
        pulse(0, 0, 0, 0, 1, 8'h12, 0);
        check("idle_rx_ignored", 32'(new_address), 32'h00);
        pulse(1, 0, 1, 0, 0, 8'h00, 0);
        check("start_drops_match", 32'(busy), 32'd0);
        idle(2);

        // Pointer 05, then writes AA, 55
        begin_txn(1'b0);
        ptr_byte(8'h05, 8'h05, 1'b0);
        write_byte(8'hAA, 8'h05, 8'h06);
        write_byte(8'h55, 8'h06, 8'h07);
        end_txn(8'h07);

        // Wrap past MaxAddress
        begin_txn(1'b0);
        ptr_byte(8'h1E, 8'h1E, 1'b0);
        write_byte(8'h11, 8'h1E, 8'h1F);
        write_byte(8'h22, 8'h1F, 8'h00);
        write_byte(8'h33, 8'h00, 8'h01);
        end_txn(8'h01);

        // Out-of-range pointers clamp to 0
        begin_txn(1'b0);
        ptr_byte(8'h40, 8'h00, 1'b1);
        write_byte(8'h77, 8'h00, 8'h01);
        end_txn(8'h01);
        begin_txn(1'b0);
        ptr_byte(8'h20, 8'h00, 1'b1);
        end_txn(8'h00);

        // Pointer exactly at MaxAddress is accepted
        begin_txn(1'b0);
        ptr_byte(8'h1F, 8'h1F, 1'b0);
        write_byte(8'h99, 8'h1F, 8'h00);
        end_txn(8'h00);

        // Write pointer, repeated START, read three bytes
        begin_txn(1'b0);
        ptr_byte(8'h10, 8'h10, 1'b0);
        begin_txn(1'b1);
        pulse(0, 0, 0, 0, 1, 8'hC3, 0);
        check("read_rx_ignored", 32'(new_address), 32'h10);
        idle(2);
        read_byte(8'h11);
        read_byte(8'h12);
        read_byte(8'h13);
        end_txn(8'h13);

        // STOP coincident with a data byte
        begin_txn(1'b0);
        ptr_byte(8'h08, 8'h08, 1'b0);
        pulse(0, 1, 0, 0, 1, 8'hEE, 0);
        check("stop_rx_new_address", 32'(new_address), 32'h08);
        check("stop_rx_busy", 32'(busy), 32'd0);
        idle(2);
        check("stop_rx_ptr", 32'(address_bus), 32'h08);

        // Reset while a write strobe and increment are pending
        begin_txn(1'b0);
        ptr_byte(8'h0A, 8'h0A, 1'b0);
        pulse(0, 0, 0, 0, 1, 8'h5A, 0);
        rst = 1'b1;
        #1;
        check("abort_reg_write", 32'(reg_write), 32'd0);
        check("abort_reg_write_data", 32'(reg_write_data), 32'd0);
        check("abort_addr_error", 32'(addr_error), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_new_address", 32'(new_address), 32'h0A);
        idle(2);
        rst = 1'b0;
        idle(2);
        check("abort_ptr_kept", 32'(address_bus), 32'h0A);
        check("abort_busy_after", 32'(busy), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
